// File: rtl/s_axis_cc_adapt_wide_if.sv
// s_axis_cc_adapt_wide_if: bundles the TLP-side completer-completion stream
// (s_axis_cc_*) and the descriptor-side stream to the hard IP (s_axis_cc_*_a).
// The slave modport is the adapter's view; the master modport is the view of
// whatever drives the TLP stream and sinks the descriptor stream.
`timescale 1ns/1ps
interface s_axis_cc_adapt_wide_if #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 33
);
  // TLP-format side
  logic [DATA_WIDTH-1:0]    s_axis_cc_tdata;
  logic [KEEP_WIDTH-1:0]    s_axis_cc_tkeep;
  logic                     s_axis_cc_tlast;
  logic                     s_axis_cc_tvalid;
  logic [3:0]               s_axis_cc_tuser;
  logic [3:0]               s_axis_cc_tready;
  // Descriptor-format side
  logic [DATA_WIDTH-1:0]    s_axis_cc_tdata_a;
  logic [DATA_WIDTH/32-1:0] s_axis_cc_tkeep_a;
  logic                     s_axis_cc_tlast_a;
  logic                     s_axis_cc_tvalid_a;
  logic [USER_WIDTH-1:0]    s_axis_cc_tuser_a;
  logic [3:0]               s_axis_cc_tready_a;

  modport slave (
    input  s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tlast,
           s_axis_cc_tvalid, s_axis_cc_tuser, s_axis_cc_tready_a,
    output s_axis_cc_tready, s_axis_cc_tdata_a, s_axis_cc_tkeep_a,
           s_axis_cc_tlast_a, s_axis_cc_tvalid_a, s_axis_cc_tuser_a
  );

  modport master (
    output s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tlast,
           s_axis_cc_tvalid, s_axis_cc_tuser, s_axis_cc_tready_a,
    input  s_axis_cc_tready, s_axis_cc_tdata_a, s_axis_cc_tkeep_a,
           s_axis_cc_tlast_a, s_axis_cc_tvalid_a, s_axis_cc_tuser_a
  );
endinterface

// File: rtl/s_axis_cc_adapt_wide.sv
// s_axis_cc_adapt_wide: converts TLP-format completions into the hard IP's
// CC descriptor format. Beats are buffered in a small FIFO; on the first beat
// of each TLP the 3-DW TLP header is rewritten into the 96-bit descriptor.
// Optional feature: define LITEPCIE_CC_PARITY_EN to drive per-byte odd parity
// of the outgoing data on tuser_a[KEEP_WIDTH:1].
`timescale 1ns/1ps
module s_axis_cc_adapt_wide #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int FIFO_DEPTH = 4,
  parameter int USER_WIDTH = 33
) (
  input logic                   user_clk,
  input logic                   user_reset,
  s_axis_cc_adapt_wide_if.slave bus
);

  localparam int DKW = DATA_WIDTH / 32;
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic                  disc;
    logic                  ecrc;
    logic [DKW-1:0]        keep;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } entry_t;

  entry_t                mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  sop_q, sop_d;

  logic                  full, empty, push, pop;
  logic [DKW-1:0]        dkeep;
  entry_t                head;
  logic [95:0]           desc;
  logic [DATA_WIDTH-1:0] data_out;
  logic [USER_WIDTH-1:0] user_out;
  logic                  unused_bits;

  assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.s_axis_cc_tvalid && !full;
  assign pop   = !empty && bus.s_axis_cc_tready_a[0];
  assign head  = mem_q[rd_ptr_q];

  // tuser[2:1] and tready_a[3:1] carry nothing this block acts on
  assign unused_bits = ^{bus.s_axis_cc_tuser[2:1], bus.s_axis_cc_tready_a[3:1]};

  // Byte enables collapse to dword enables: a dword is live if any byte is
  always_comb begin
    dkeep = '0;
    for (int unsigned i = 0; i < KEEP_WIDTH / 4; i++) begin
      dkeep[i] = |bus.s_axis_cc_tkeep[4*i +: 4];
    end
  end

  // Buffer storage; contents need no reset since occupancy gates every read
  always_ff @(posedge user_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{disc: bus.s_axis_cc_tuser[3],
                           ecrc: bus.s_axis_cc_tuser[0],
                           keep: dkeep,
                           data: bus.s_axis_cc_tdata,
                           last: bus.s_axis_cc_tlast};
    end
  end

  // Next-state for pointers, occupancy and the start-of-packet flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sop_d    = sop_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      sop_d    = head.last;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy/SOP registers; reset drops any partial TLP
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sop_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sop_q    <= sop_d;
    end
  end

  // Rewrite the 3-DW TLP header at the FIFO head into the CC descriptor
  always_comb begin
    desc        = '0;
    desc[6:0]   = head.data[70:64];                    // lower address
    desc[28:16] = {1'b0, head.data[43:32]};            // byte count
    desc[29]    = (head.data[29:24] == 6'b001011);     // locked read completion
    desc[41:32] = head.data[9:0];                      // dword count
    desc[44:42] = head.data[47:45];                    // completion status
    desc[45]    = head.data[14];                       // poisoned
    desc[63:48] = head.data[95:80];                    // requester id
    desc[71:64] = head.data[79:72];                    // tag
    desc[87:72] = head.data[63:48];                    // completer id
    desc[91:89] = head.data[22:20];                    // traffic class
    desc[94:92] = {1'b0, head.data[13:12]};            // attributes
    desc[95]    = head.data[15] | head.ecrc;           // force ECRC
  end

  // Descriptor replaces the header only on the first beat of a TLP
  always_comb begin
    data_out = head.data;
    if (sop_q) begin
      data_out[95:0] = desc;
    end
  end

  // Sideband: discontinue plus optional parity, forced to zero when idle
  always_comb begin
    user_out = '0;
    if (!empty) begin
      user_out[0] = head.disc;
`ifdef LITEPCIE_CC_PARITY_EN
      for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
        if (i + 1 < USER_WIDTH) begin
          user_out[i+1] = ~(^data_out[8*i +: 8]);
        end
      end
`endif
    end
  end

  assign bus.s_axis_cc_tready   = {4{~full}};
  assign bus.s_axis_cc_tvalid_a = !empty;
  assign bus.s_axis_cc_tdata_a  = data_out;
  assign bus.s_axis_cc_tkeep_a  = head.keep;
  assign bus.s_axis_cc_tlast_a  = head.last;
  assign bus.s_axis_cc_tuser_a  = user_out;

endmodule

// File: tb/tb_s_axis_cc_adapt_wide.sv
// tb_s_axis_cc_adapt_wide: directed stimulus for the CC adapter with a
// scoreboard of expected descriptor-side beats and a negedge monitor.
`timescale 1ns/1ps
module tb_s_axis_cc_adapt_wide;

  localparam int DW  = 128;
  localparam int KW  = DW / 8;
  localparam int DKW = DW / 32;
  localparam int UW  = 33;

  logic user_clk   = 1'b0;
  logic user_reset = 1'b1;

  s_axis_cc_adapt_wide_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) bus ();

  s_axis_cc_adapt_wide #(
    .DATA_WIDTH(DW),
    .KEEP_WIDTH(KW),
    .FIFO_DEPTH(4),
    .USER_WIDTH(UW)
  ) dut (
    .user_clk  (user_clk),
    .user_reset(user_reset),
    .bus       (bus)
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    logic [DW-1:0]  data;
    logic [DKW-1:0] keep;
    logic           last;
    logic [UW-1:0]  user;
  } beat_t;

  int    n_assert = 0;
  int    n_fail   = 0;
  beat_t sb[$];
  logic  m_sop = 1'b1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Descriptor assembled dword by dword from the header fields
  function automatic logic [95:0] mk_desc(input logic [DW-1:0] d, input logic ecrc);
    logic [6:0]  lower_addr = d[70:64];
    logic [11:0] byte_cnt   = d[43:32];
    logic        locked     = (d[29:24] == 6'b001011);
    logic [9:0]  dw_cnt     = d[9:0];
    logic [2:0]  status     = d[47:45];
    logic        poison     = d[14];
    logic [15:0] req_id     = d[95:80];
    logic [7:0]  tag        = d[79:72];
    logic [15:0] cpl_id     = d[63:48];
    logic [2:0]  tc         = d[22:20];
    logic [1:0]  attr       = d[13:12];
    logic        td         = d[15];
    logic [31:0] dw0, dw1, dw2;
    dw0 = {2'b00, locked, 1'b0, byte_cnt, 9'b0, lower_addr};
    dw1 = {req_id, 2'b00, poison, status, dw_cnt};
    dw2 = {td | ecrc, 1'b0, attr, tc, 1'b0, cpl_id, tag};
    return {dw2, dw1, dw0};
  endfunction

  function automatic beat_t model(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                  input logic l, input logic [3:0] u, input logic sop);
    beat_t b;
    b.data = d;
    if (sop) b.data[95:0] = mk_desc(d, u[0]);
    for (int j = 0; j < DKW; j++) b.keep[j] = (k[4*j +: 4] != 4'h0);
    b.last    = l;
    b.user    = '0;
    b.user[0] = u[3];
`ifdef LITEPCIE_CC_PARITY_EN
    for (int i = 0; i < KW; i++) b.user[i+1] = ~(^b.data[8*i +: 8]);
`endif
    return b;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input logic [DW-1:0] d, input logic [KW-1:0] k,
                       input logic l, input logic [3:0] u);
    bus.s_axis_cc_tdata  = d;
    bus.s_axis_cc_tkeep  = k;
    bus.s_axis_cc_tlast  = l;
    bus.s_axis_cc_tuser  = u;
    bus.s_axis_cc_tvalid = 1'b1;
  endtask

  // Present one beat until accepted; bp=1 randomises tready_a while waiting
  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k,
                      input logic l, input logic [3:0] u, input logic bp);
    int   waited = 0;
    logic acc    = 1'b0;
    drive(d, k, l, u);
    while (!acc && waited < 50) begin
      @(negedge user_clk);
      acc = bus.s_axis_cc_tready[0];
      @(posedge user_clk);
      #1;
      waited++;
      if (bp) bus.s_axis_cc_tready_a = {3'b000, ($urandom_range(0, 3) != 0)};
    end
    if (acc) begin
      sb.push_back(model(d, k, l, u, m_sop));
      m_sop = l;
    end else begin
      chk("send_timeout", acc, 1'b1);
    end
    bus.s_axis_cc_tvalid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge user_clk);
    #1;
  endtask

  task automatic drain();
    int w = 0;
    bus.s_axis_cc_tready_a = 4'hF;
    while (sb.size() != 0 && w < 200) begin
      cycles(1);
      w++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic do_reset(input int n);
    user_reset           = 1'b1;
    bus.s_axis_cc_tvalid = 1'b0;
    cycles(n);
    user_reset = 1'b0;
    sb.delete();
    m_sop = 1'b1;
  endtask

  task automatic chk_idle(input string tag);
    @(negedge user_clk);
    chk({tag, "_tvalid_a"}, bus.s_axis_cc_tvalid_a, 1'b0);
    chk({tag, "_tready"},   bus.s_axis_cc_tready,   4'hF);
    chk({tag, "_tuser_a"},  bus.s_axis_cc_tuser_a,  '0);
    cycles(1);
  endtask

  // Monitor: compare popped beats against the scoreboard, check stall stability
  logic  hold_v = 1'b0;
  beat_t held;
  beat_t mon_e;
  always @(negedge user_clk) begin
    if (user_reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_tvalid", bus.s_axis_cc_tvalid_a, 1'b1);
        chk("hold_tdata",  bus.s_axis_cc_tdata_a,  held.data);
        chk("hold_tkeep",  bus.s_axis_cc_tkeep_a,  held.keep);
        chk("hold_tlast",  bus.s_axis_cc_tlast_a,  held.last);
        chk("hold_tuser",  bus.s_axis_cc_tuser_a,  held.user);
      end
      if (bus.s_axis_cc_tvalid_a && bus.s_axis_cc_tready_a[0]) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", bus.s_axis_cc_tvalid_a, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          chk("out_tdata", bus.s_axis_cc_tdata_a, mon_e.data);
          chk("out_tkeep", bus.s_axis_cc_tkeep_a, mon_e.keep);
          chk("out_tlast", bus.s_axis_cc_tlast_a, mon_e.last);
          chk("out_tuser", bus.s_axis_cc_tuser_a, mon_e.user);
        end
      end
      hold_v = bus.s_axis_cc_tvalid_a && !bus.s_axis_cc_tready_a[0];
      if (hold_v) begin
        held.data = bus.s_axis_cc_tdata_a;
        held.keep = bus.s_axis_cc_tkeep_a;
        held.last = bus.s_axis_cc_tlast_a;
        held.user = bus.s_axis_cc_tuser_a;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] fd [6];
    logic          fl [6];
    int            idx;
    int            acc_cnt;
    logic          acc;

    bus.s_axis_cc_tdata    = '0;
    bus.s_axis_cc_tkeep    = '0;
    bus.s_axis_cc_tlast    = 1'b0;
    bus.s_axis_cc_tvalid   = 1'b0;
    bus.s_axis_cc_tuser    = '0;
    bus.s_axis_cc_tready_a = 4'hF;
    user_reset = 1'b1;
    cycles(3);
    user_reset = 1'b0;
    m_sop = 1'b1;

    // Reset state
    chk_idle("reset");

    // 1-DW completion with hand-derived descriptor
    bus.s_axis_cc_tready_a = 4'h0;
    d = {32'hDEADBEEF, 32'h01005A10, 32'h02000004, 32'h4A000001};
    send(d, 16'hFFFF, 1'b1, 4'h0, 1'b0);
    @(negedge user_clk);
    chk("cpl1_tvalid_a", bus.s_axis_cc_tvalid_a, 1'b1);
    chk("cpl1_tdata_a",  bus.s_axis_cc_tdata_a,
        128'hDEADBEEF_0002005A_01000001_00040010);
    chk("cpl1_tkeep_a",  bus.s_axis_cc_tkeep_a, 4'hF);
    chk("cpl1_tlast_a",  bus.s_axis_cc_tlast_a, 1'b1);
    cycles(1);
    drain();

    // Locked-read completion with ECRC requested through tuser[0]
    bus.s_axis_cc_tready_a = 4'h0;
    d = {32'h12345678, 32'h0200AB20, 32'h02000008, 32'h4B000002};
    send(d, 16'hFFFF, 1'b1, 4'h1, 1'b0);
    @(negedge user_clk);
    chk("lock_bit29", bus.s_axis_cc_tdata_a[29], 1'b1);
    chk("lock_bit95", bus.s_axis_cc_tdata_a[95], 1'b1);
    cycles(1);
    drain();

    // 3-beat TLP: descriptor on beat 0 only; then a single beat to confirm SOP
    d = rnd_data();
    d[9:0] = 10'd10;
    send(d,          16'hFFFF, 1'b0, 4'h0, 1'b0);
    send(rnd_data(), 16'hFFFF, 1'b0, 4'h6, 1'b0);
    send(rnd_data(), 16'h0FF0, 1'b1, 4'h0, 1'b0);
    send(rnd_data(), 16'h0010, 1'b1, 4'h0, 1'b0);
    drain();

    // Mixed-length TLPs under random backpressure
    for (int t = 0; t < 6; t++) begin
      int len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) begin
        send(rnd_data(), 16'(($urandom % 16'hFFFF) + 1), (b == len - 1),
             4'($urandom_range(0, 15)), 1'b1);
      end
    end
    drain();

    // Full FIFO: tready_a held low for 10 cycles
    for (int i = 0; i < 6; i++) begin
      fd[i] = rnd_data();
      fl[i] = (i == 0 || i == 2 || i == 5);
    end
    bus.s_axis_cc_tready_a = 4'h0;
    idx = 0;
    acc_cnt = 0;
    drive(fd[0], 16'hFFFF, fl[0], 4'h0);
    repeat (10) begin
      @(negedge user_clk);
      acc = bus.s_axis_cc_tready[0];
      @(posedge user_clk);
      #1;
      if (acc && bus.s_axis_cc_tvalid && idx < 6) begin
        sb.push_back(model(fd[idx], 16'hFFFF, fl[idx], 4'h0, m_sop));
        m_sop = fl[idx];
        acc_cnt++;
        idx++;
        if (idx < 6) drive(fd[idx], 16'hFFFF, fl[idx], 4'h0);
        else bus.s_axis_cc_tvalid = 1'b0;
      end
    end
    chk("full_accepted", acc_cnt, 4);
    @(negedge user_clk);
    chk("full_tready",   bus.s_axis_cc_tready,   4'h0);
    chk("full_tvalid_a", bus.s_axis_cc_tvalid_a, 1'b1);
    cycles(1);
    bus.s_axis_cc_tready_a = 4'hF;
    while (idx < 6) begin
      send(fd[idx], 16'hFFFF, fl[idx], 4'h0, 1'b0);
      idx++;
    end
    drain();

    // Reset in the middle of a 3-beat TLP
    send(rnd_data(), 16'hFFFF, 1'b0, 4'h0, 1'b0);
    cycles(2);
    do_reset(2);
    chk_idle("midrst");
    bus.s_axis_cc_tready_a = 4'h0;
    d = rnd_data();
    send(d, 16'hFFFF, 1'b1, 4'h8, 1'b0);
    @(negedge user_clk);
    chk("postrst_desc",  bus.s_axis_cc_tdata_a[95:0], mk_desc(d, 1'b0));
    chk("postrst_disc",  bus.s_axis_cc_tuser_a[0],    1'b1);
    cycles(1);
    drain();

    // Parity bit for output byte 0 (descriptor lower address)
    for (int v = 0; v < 2; v++) begin
      bus.s_axis_cc_tready_a = 4'h0;
      d = rnd_data();
      d[71:64] = 8'(v);
      send(d, 16'hFFFF, 1'b1, 4'h0, 1'b0);
      @(negedge user_clk);
      chk("byte0_value", bus.s_axis_cc_tdata_a[7:0], 8'(v));
`ifdef LITEPCIE_CC_PARITY_EN
      chk("parity_byte0", bus.s_axis_cc_tuser_a[1], (v == 0));
`else
      chk("noparity_byte0", bus.s_axis_cc_tuser_a[1], 1'b0);
`endif
      cycles(1);
      drain();
    end

    cycles(3);
    chk("final_tvalid_a", bus.s_axis_cc_tvalid_a, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
